// File: rtl/sram_b_15abits_arbiter_if.sv
// Requester-side bus of sram_b_15abits_arbiter: valid/ready request channel
// plus the shared read-response channel, with fields packed per requester.
interface sram_b_15abits_arbiter_if #(
  parameter int NREQ  = 2,
  parameter int ABITS = 15,
  parameter int DBITS = 8
);
  logic [NREQ-1:0]       req_valid;
  logic [NREQ-1:0]       req_ready;
  logic [NREQ-1:0]       req_we;
  logic [NREQ*ABITS-1:0] req_a;
  logic [NREQ*DBITS-1:0] req_d;
  logic [NREQ*DBITS-1:0] req_wem;
  logic [NREQ-1:0]       rsp_valid;
  logic [DBITS-1:0]      rsp_q;

  modport master (
    output req_valid, req_we, req_a, req_d, req_wem,
    input  req_ready, rsp_valid, rsp_q
  );

  modport slave (
    input  req_valid, req_we, req_a, req_d, req_wem,
    output req_ready, rsp_valid, rsp_q
  );
endinterface

// File: rtl/sram_b_15abits_arbiter.sv
// Round-robin arbiter sharing a 1W/1R SRAM between NREQ requesters.
// Optional zero-fill of the memory after reset: define SRAM_B_ARB_ZERO_INIT_EN.
module sram_b_15abits_arbiter #(
  parameter int NREQ  = 2,
  parameter int ABITS = 15,
  parameter int DBITS = 8
) (
  input  logic                   clk,
  input  logic                   rst_n,
  sram_b_15abits_arbiter_if.slave bus,
  output logic                   ce0,
  output logic [ABITS-1:0]       a0,
  output logic [DBITS-1:0]       d0,
  output logic                   we0,
  output logic [DBITS-1:0]       wem0,
  output logic                   ce1,
  output logic [ABITS-1:0]       a1,
  input  logic [DBITS-1:0]       q1,
  output logic                   init_busy
);
  localparam int PW = (NREQ > 1) ? $clog2(NREQ) : 1;
  typedef logic [PW-1:0] ptr_t;
  typedef struct packed {
    logic hit;
    ptr_t idx;
  } pick_t;

  ptr_t  wptr, rptr, rsel;
  logic  rvld;
  logic  run, init_active;
  logic  wgnt, rgnt;
  pick_t wp, rp;
  logic [ABITS-1:0] init_addr;
  logic [ABITS-1:0] req_addr [NREQ];
  logic [DBITS-1:0] req_data [NREQ];
  logic [DBITS-1:0] req_mask [NREQ];

  // First set bit of cand at or after ptr, wrapping modulo NREQ.
  function automatic pick_t pick(input logic [NREQ-1:0] cand, input ptr_t ptr);
    int idx;
    pick = '0;
    for (int k = NREQ - 1; k >= 0; k--) begin
      idx = int'(ptr) + k;
      if (idx >= NREQ) idx -= NREQ;
      if (cand[idx]) pick = '{hit: 1'b1, idx: ptr_t'(idx)};
    end
  endfunction

  function automatic ptr_t after(input ptr_t w);
    return (w == ptr_t'(NREQ - 1)) ? '0 : w + ptr_t'(1);
  endfunction

`ifdef SRAM_B_ARB_ZERO_INIT_EN
  typedef enum logic {ST_INIT, ST_RUN} state_t;
  state_t state, state_nxt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= ST_INIT;
      init_addr <= '0;
    end else begin
      state <= state_nxt;
      if (state == ST_INIT) init_addr <= init_addr + 1'b1;
    end
  end

  always_comb begin
    state_nxt = state;
    if (state == ST_INIT && init_addr == '1) state_nxt = ST_RUN;
  end

  // Gated with rst_n so nothing reaches the memory while reset is held.
  assign init_active = rst_n && (state == ST_INIT);
  assign run         = rst_n && (state == ST_RUN);
`else
  assign init_active = 1'b0;
  assign run         = rst_n;
  assign init_addr   = '0;
`endif
  assign init_busy = init_active;

  always_comb begin
    for (int i = 0; i < NREQ; i++) begin
      req_addr[i] = bus.req_a[i*ABITS +: ABITS];
      req_data[i] = bus.req_d[i*DBITS +: DBITS];
      req_mask[i] = bus.req_wem[i*DBITS +: DBITS];
    end
  end

  // NOTE: every output gets a default before any branch so no latch is inferred.
  always_comb begin
    bus.req_ready = '0;
    ce0  = 1'b0;
    we0  = 1'b0;
    a0   = '0;
    d0   = '0;
    wem0 = '0;
    ce1  = 1'b0;
    a1   = '0;
    wp   = pick(bus.req_valid & bus.req_we, wptr);
    rp   = pick(bus.req_valid & ~bus.req_we, rptr);
    wgnt = run && wp.hit;
    // A read colliding with this cycle's write waits and later sees the new data.
    rgnt = run && rp.hit && !(wgnt && req_addr[rp.idx] == req_addr[wp.idx]);
    if (init_active) begin
      ce0  = 1'b1;
      we0  = 1'b1;
      a0   = init_addr;
      wem0 = '1;
    end
    if (wgnt) begin
      bus.req_ready[wp.idx] = 1'b1;
      ce0  = 1'b1;
      we0  = 1'b1;
      a0   = req_addr[wp.idx];
      d0   = req_data[wp.idx];
      wem0 = req_mask[wp.idx];
    end
    if (rgnt) begin
      bus.req_ready[rp.idx] = 1'b1;
      ce1 = 1'b1;
      a1  = req_addr[rp.idx];
    end
  end

  // NOTE: sequential state uses non-blocking assignments only.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wptr <= '0;
      rptr <= '0;
      rsel <= '0;
      rvld <= 1'b0;
    end else begin
      if (wgnt) wptr <= after(wp.idx);
      if (rgnt) rptr <= after(rp.idx);
      rsel <= rp.idx;
      rvld <= rgnt;
    end
  end

  always_comb begin
    for (int i = 0; i < NREQ; i++) bus.rsp_valid[i] = rvld && (rsel == ptr_t'(i));
  end
  assign bus.rsp_q = q1;

endmodule

// File: tb/tb_sram_b_15abits_arbiter.sv
// Directed bench for sram_b_15abits_arbiter with a behavioural 32768x8 masked SRAM.
module tb_sram_b_15abits_arbiter;
  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        ce0, we0, ce1, init_busy;
  logic [14:0] a0, a1;
  logic [7:0]  d0, wem0, q1;
  logic [7:0]  mem [32768];
  int total = 0;
  int bad = 0;

  sram_b_15abits_arbiter_if #(.NREQ(2), .ABITS(15), .DBITS(8)) bus ();

  sram_b_15abits_arbiter #(.NREQ(2), .ABITS(15), .DBITS(8)) dut (
    .clk(clk), .rst_n(rst_n), .bus(bus),
    .ce0(ce0), .a0(a0), .d0(d0), .we0(we0), .wem0(wem0),
    .ce1(ce1), .a1(a1), .q1(q1), .init_busy(init_busy)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (ce0 && we0) mem[a0] <= (mem[a0] & ~wem0) | (d0 & wem0);
    if (ce1) q1 <= mem[a1];
  end

  initial begin
    #1500000;
    $display("FAIL watchdog expired total=%0d bad=%0d", total, bad);
    $fatal(1, "timeout");
  end

  task automatic drive(input int i, input bit we, input logic [14:0] a,
                       input logic [7:0] d, input logic [7:0] m);
    bus.req_valid[i]        = 1'b1;
    bus.req_we[i]           = we;
    bus.req_a[i*15 +: 15]   = a;
    bus.req_d[i*8 +: 8]     = d;
    bus.req_wem[i*8 +: 8]   = m;
  endtask

  task automatic drop(input int i);
    bus.req_valid[i] = 1'b0;
  endtask

  task automatic idle();
    bus.req_valid = '0;
    bus.req_we    = '0;
    bus.req_a     = '0;
    bus.req_d     = '0;
    bus.req_wem   = '0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    idle();
    @(negedge clk);
    drive(0, 1, 15'h0001, 8'h01, 8'hFF);
    drive(1, 0, 15'h0002, 8'h00, 8'h00);
    #1;
    total++; if (bus.req_ready !== 2'b00) begin bad++; $display("FAIL rst_ready got=%b exp=00", bus.req_ready); end
    total++; if (ce0 !== 1'b0) begin bad++; $display("FAIL rst_ce0 got=%b exp=0", ce0); end
    total++; if (ce1 !== 1'b0) begin bad++; $display("FAIL rst_ce1 got=%b exp=0", ce1); end
    total++; if (bus.rsp_valid !== 2'b00) begin bad++; $display("FAIL rst_rsp_valid got=%b exp=00", bus.rsp_valid); end
    total++; if (init_busy !== 1'b0) begin bad++; $display("FAIL rst_init_busy got=%b exp=0", init_busy); end
    idle();
  endtask

`ifdef SRAM_B_ARB_ZERO_INIT_EN
  task automatic test_zero_init();
    int n;
    int viol;
    viol = 0;
    drive(1, 0, 15'h1234, 8'h00, 8'h00);
    @(negedge clk); rst_n = 1'b1; #1;
    for (int k = 0; k < 100; k++) begin
      if (k > 0) begin @(negedge clk); #1; end
      if (init_busy !== 1'b1 || bus.req_ready !== 2'b00 || ce1 !== 1'b0 || ce0 !== 1'b1 || a0 !== 15'(k)) viol++;
    end
    total++; if (viol != 0) begin bad++; $display("FAIL init_first100 got=%0d violations exp=0", viol); end
    @(negedge clk); rst_n = 1'b0; #1;
    total++; if (init_busy !== 1'b0) begin bad++; $display("FAIL init_rst_busy got=%b exp=0", init_busy); end
    total++; if (ce0 !== 1'b0) begin bad++; $display("FAIL init_rst_ce0 got=%b exp=0", ce0); end
    @(negedge clk); rst_n = 1'b1; #1;
    total++; if (a0 !== 15'h0000) begin bad++; $display("FAIL init_restart_a0 got=%h exp=0000", a0); end
    n = 0;
    viol = 0;
    while (init_busy === 1'b1 && n < 40000) begin
      if (bus.req_ready !== 2'b00 || ce1 !== 1'b0 || ce0 !== 1'b1 || a0 !== n[14:0] || d0 !== 8'h00 || wem0 !== 8'hFF) viol++;
      n++;
      @(negedge clk); #1;
    end
    total++; if (n != 32768) begin bad++; $display("FAIL init_busy_cycles got=%0d exp=32768", n); end
    total++; if (viol != 0) begin bad++; $display("FAIL init_writes got=%0d violations exp=0", viol); end
    total++; if (bus.req_ready !== 2'b10 || a1 !== 15'h1234) begin bad++; $display("FAIL init_read_grant got=%b/%h exp=10/1234", bus.req_ready, a1); end
    @(negedge clk); idle(); #1;
    total++; if (bus.rsp_valid !== 2'b10 || bus.rsp_q !== 8'h00) begin bad++; $display("FAIL init_read_zero got=%b/%h exp=10/00", bus.rsp_valid, bus.rsp_q); end
  endtask
`else
  task automatic test_no_init();
    @(negedge clk); rst_n = 1'b1; #1;
    total++; if (init_busy !== 1'b0) begin bad++; $display("FAIL no_init_busy got=%b exp=0", init_busy); end
  endtask
`endif

  task automatic test_two_writes();
    @(negedge clk);
    drive(0, 1, 15'h0010, 8'hAA, 8'hFF);
    drive(1, 1, 15'h0020, 8'h55, 8'hFF);
    #1;
    total++; if (bus.req_ready !== 2'b01 || a0 !== 15'h0010 || d0 !== 8'hAA || we0 !== 1'b1) begin bad++; $display("FAIL wr_c1 got=%b/%h/%h exp=01/0010/aa", bus.req_ready, a0, d0); end
    @(negedge clk);
    drive(0, 1, 15'h0030, 8'h11, 8'hFF);
    #1;
    total++; if (bus.req_ready !== 2'b10 || a0 !== 15'h0020 || d0 !== 8'h55) begin bad++; $display("FAIL wr_c2_rr got=%b/%h/%h exp=10/0020/55", bus.req_ready, a0, d0); end
    @(negedge clk); drop(1); #1;
    total++; if (bus.req_ready !== 2'b01 || a0 !== 15'h0030) begin bad++; $display("FAIL wr_c3 got=%b/%h exp=01/0030", bus.req_ready, a0); end
    @(negedge clk);
    idle();
    drive(0, 0, 15'h0010, 8'h00, 8'h00);
    drive(1, 0, 15'h0020, 8'h00, 8'h00);
    #1;
    total++; if (bus.req_ready !== 2'b01 || ce1 !== 1'b1 || a1 !== 15'h0010) begin bad++; $display("FAIL rd_c1 got=%b/%b/%h exp=01/1/0010", bus.req_ready, ce1, a1); end
    @(negedge clk); drop(0); #1;
    total++; if (bus.req_ready !== 2'b10 || a1 !== 15'h0020) begin bad++; $display("FAIL rd_c2 got=%b/%h exp=10/0020", bus.req_ready, a1); end
    total++; if (bus.rsp_valid !== 2'b01 || bus.rsp_q !== 8'hAA) begin bad++; $display("FAIL rd_rsp0 got=%b/%h exp=01/aa", bus.rsp_valid, bus.rsp_q); end
    @(negedge clk); idle(); #1;
    total++; if (bus.rsp_valid !== 2'b10 || bus.rsp_q !== 8'h55) begin bad++; $display("FAIL rd_rsp1 got=%b/%h exp=10/55", bus.rsp_valid, bus.rsp_q); end
  endtask

  task automatic test_concurrent();
    @(negedge clk);
    drive(0, 1, 15'h7FFF, 8'h3C, 8'hFF);
    drive(1, 0, 15'h0010, 8'h00, 8'h00);
    #1;
    total++; if (bus.req_ready !== 2'b11 || ce0 !== 1'b1 || ce1 !== 1'b1 || a0 !== 15'h7FFF || a1 !== 15'h0010) begin bad++; $display("FAIL conc_grant got=%b/%h/%h exp=11/7fff/0010", bus.req_ready, a0, a1); end
    @(negedge clk); idle(); #1;
    total++; if (bus.rsp_valid !== 2'b10 || bus.rsp_q !== 8'hAA) begin bad++; $display("FAIL conc_rsp got=%b/%h exp=10/aa", bus.rsp_valid, bus.rsp_q); end
    total++; if (ce0 !== 1'b0 || ce1 !== 1'b0 || a0 !== 15'h0 || d0 !== 8'h0 || wem0 !== 8'h0 || a1 !== 15'h0) begin bad++; $display("FAIL idle_outputs got=%b%b/%h/%h/%h/%h exp=00/0/0/0/0", ce0, ce1, a0, d0, wem0, a1); end
  endtask

  task automatic test_hazard();
    @(negedge clk);
    drive(0, 1, 15'h0100, 8'h12, 8'hFF);
    drive(1, 0, 15'h0100, 8'h00, 8'h00);
    #1;
    total++; if (bus.req_ready !== 2'b01 || ce0 !== 1'b1 || ce1 !== 1'b0) begin bad++; $display("FAIL haz_stall got=%b/%b/%b exp=01/1/0", bus.req_ready, ce0, ce1); end
    @(negedge clk); drop(0); #1;
    total++; if (bus.req_ready !== 2'b10 || ce1 !== 1'b1 || a1 !== 15'h0100 || bus.rsp_valid !== 2'b00) begin bad++; $display("FAIL haz_retry got=%b/%b/%h/%b exp=10/1/0100/00", bus.req_ready, ce1, a1, bus.rsp_valid); end
    @(negedge clk); idle(); #1;
    total++; if (bus.rsp_valid !== 2'b10 || bus.rsp_q !== 8'h12) begin bad++; $display("FAIL haz_data got=%b/%h exp=10/12", bus.rsp_valid, bus.rsp_q); end
  endtask

  task automatic test_fairness();
    logic [1:0] exp_rdy;
    logic [1:0] prev_rdy;
    logic [7:0] prev_q;
    prev_rdy = 2'b00;
    prev_q   = 8'h00;
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      drive(0, 0, 15'h0010, 8'h00, 8'h00);
      drive(1, 0, 15'h0020, 8'h00, 8'h00);
      #1;
      exp_rdy = (k % 2 == 0) ? 2'b01 : 2'b10;
      total++; if (bus.req_ready !== exp_rdy) begin bad++; $display("FAIL fair_grant%0d got=%b exp=%b", k, bus.req_ready, exp_rdy); end
      if (k > 0) begin
        total++; if (bus.rsp_valid !== prev_rdy || bus.rsp_q !== prev_q) begin bad++; $display("FAIL fair_rsp%0d got=%b/%h exp=%b/%h", k, bus.rsp_valid, bus.rsp_q, prev_rdy, prev_q); end
      end
      prev_rdy = exp_rdy;
      prev_q   = (k % 2 == 0) ? 8'hAA : 8'h55;
    end
    @(negedge clk); idle(); #1;
    total++; if (bus.rsp_valid !== 2'b10 || bus.rsp_q !== 8'h55) begin bad++; $display("FAIL fair_last got=%b/%h exp=10/55", bus.rsp_valid, bus.rsp_q); end
  endtask

  task automatic test_masked();
    @(negedge clk); drive(1, 1, 15'h0005, 8'hFF, 8'hFF); #1;
    total++; if (bus.req_ready !== 2'b10) begin bad++; $display("FAIL mask_fill got=%b exp=10", bus.req_ready); end
    @(negedge clk); drive(1, 1, 15'h0005, 8'h00, 8'h0F); #1;
    total++; if (bus.req_ready !== 2'b10 || wem0 !== 8'h0F || d0 !== 8'h00) begin bad++; $display("FAIL mask_wr got=%b/%h/%h exp=10/0f/00", bus.req_ready, wem0, d0); end
    @(negedge clk); drop(1); drive(0, 0, 15'h0005, 8'h00, 8'h00); #1;
    total++; if (bus.req_ready !== 2'b01) begin bad++; $display("FAIL mask_rd got=%b exp=01", bus.req_ready); end
    @(negedge clk); idle(); #1;
    total++; if (bus.rsp_valid !== 2'b01 || bus.rsp_q !== 8'hF0) begin bad++; $display("FAIL mask_data got=%b/%h exp=01/f0", bus.rsp_valid, bus.rsp_q); end
  endtask

  task automatic test_reset_mid();
    int n;
    @(negedge clk); drive(0, 1, 15'h0060, 8'h77, 8'hFF); #1;
    @(negedge clk); idle(); drive(0, 0, 15'h0010, 8'h00, 8'h00); #1;
    total++; if (bus.req_ready !== 2'b01) begin bad++; $display("FAIL rmid_rd got=%b exp=01", bus.req_ready); end
    @(negedge clk); idle(); rst_n = 1'b0; #1;
    total++; if (bus.rsp_valid !== 2'b00) begin bad++; $display("FAIL rmid_drop got=%b exp=00", bus.rsp_valid); end
    @(negedge clk); rst_n = 1'b1; #1;
    n = 0;
    while (init_busy === 1'b1 && n < 40000) begin @(negedge clk); #1; n++; end
    total++; if (init_busy !== 1'b0) begin bad++; $display("FAIL rmid_init_end got=%b exp=0", init_busy); end
    drive(0, 1, 15'h0040, 8'h01, 8'hFF);
    drive(1, 1, 15'h0050, 8'h02, 8'hFF);
    #1;
    total++; if (bus.req_ready !== 2'b01) begin bad++; $display("FAIL rmid_wptr got=%b exp=01", bus.req_ready); end
    @(negedge clk); idle();
    drive(0, 0, 15'h0010, 8'h00, 8'h00);
    drive(1, 0, 15'h0020, 8'h00, 8'h00);
    #1;
    total++; if (bus.req_ready !== 2'b01) begin bad++; $display("FAIL rmid_rptr got=%b exp=01", bus.req_ready); end
    @(negedge clk); idle();
  endtask

  initial begin
    idle();
    test_reset();
`ifdef SRAM_B_ARB_ZERO_INIT_EN
    test_zero_init();
`else
    test_no_init();
`endif
    test_two_writes();
    test_concurrent();
    test_hazard();
    test_fairness();
    test_masked();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/sram_b_15abits_arbiter.md
Name: sram_b_15abits_arbiter

Overview:
- Shares one 1-write/1-read banked SRAM (32768 x 8, 15 address bits) between NREQ requesters.
- Each requester issues read or write requests over a valid/ready handshake.
- Writes are granted onto memory port 0 and reads onto memory port 1, with independent round-robin arbitration per port.
- Read-after-write address hazards are resolved so the memory never sees the same address on both ports in one cycle.

Parameters:
- NREQ, 2, number of requesters (2..4)
- ABITS, 15, memory address width
- DBITS, 8, memory data width; WEM is a per-bit mask of the same width

Ports:
- CLK  input  1  clock
- RSTN  input  1  asynchronous active-low reset
- REQ_VALID  input  NREQ  request valid, one bit per requester
- REQ_READY  output  NREQ  request accepted this cycle
- REQ_WE  input  NREQ  1 = write, 0 = read
- REQ_A  input  NREQ*ABITS  packed addresses; requester i at [i*ABITS +: ABITS]
- REQ_D  input  NREQ*DBITS  packed write data
- REQ_WEM  input  NREQ*DBITS  packed write bit-mask
- RSP_VALID  output  NREQ  read data valid for requester i
- RSP_Q  output  DBITS  read data, shared by all requesters, qualified by RSP_VALID
- INIT_BUSY  output  1  memory initialisation in progress
- CE0, A0[ABITS], D0[DBITS], WE0, WEM0[DBITS]  output  memory write port
- CE1, A1[ABITS]  output  memory read port
- Q1  input  DBITS  memory read data, valid the cycle after CE1

Behaviour:
- Reset (RSTN low, asynchronous):
  - write pointer wptr = 0, read pointer rptr = 0.
  - RSP_VALID = 0, INIT_BUSY = 0.
  - All REQ_READY = 0; CE0 = CE1 = 0 while RSTN low.
- Candidates each cycle:
  - Write candidates: REQ_VALID[i] & REQ_WE[i].
  - Read candidates: REQ_VALID[i] & ~REQ_WE[i].
- Write arbitration:
  - Winner is the first candidate at or after wptr, modulo NREQ.
  - REQ_READY[winner] = 1 combinationally.
  - Memory write port driven in the same cycle: CE0 = 1, WE0 = 1, A0/D0/WEM0 from the winner.
  - On grant, wptr <= winner+1 mod NREQ; otherwise wptr holds.
- Read arbitration uses the same rule with rptr and drives CE1 = 1, A1.
- A requester is at most one candidate per cycle (one request per requester), so it never wins both ports.
- Hazard:
  - If a write is granted and the read winner's address equals the write address, the read is not granted.
  - In that case REQ_READY is low for the reader, CE1 = 0, and rptr holds.
  - The read is retried next cycle and returns post-write data.
- Read response, latency 1:
  - Registered rsel <= read winner, rvld <= read granted.
  - RSP_VALID[i] = rvld & (rsel == i); RSP_Q = Q1, combinational from the memory.
  - No response backpressure; the requester must sink RSP in the valid cycle.
- Back-to-back reads are supported every cycle; throughput is 1 write + 1 read per cycle.
- Idle cycles: CE0 = CE1 = 0 and A0/D0/WEM0/A1 = 0.
- Holding rule: a requester holds REQ_VALID, WE, A, D and WEM stable until READY; a change before grant is legal but undefined for ordering.
- Reset mid-operation:
  - Outstanding response is dropped (RSP_VALID = 0 next cycle at the latest).
  - Pointers return to 0.

Optional Feature:
- Macro SRAM_B_ARB_ZERO_INIT_EN.
- Defined:
  - After RSTN deasserts, an FSM INIT -> RUN zero-fills memory.
  - INIT: a counter addr steps 0..2^ABITS-1, one write per cycle: CE0 = 1, WE0 = 1, A0 = addr, D0 = 0, WEM0 = all ones.
  - INIT_BUSY = 1 throughout INIT; all REQ_READY = 0; CE1 = 0.
  - Enters RUN the cycle after addr = 2^ABITS-1 is written; INIT_BUSY falls then.
  - Reset during INIT restarts from addr 0.
- Undefined: the FSM is absent, the block starts in RUN, and INIT_BUSY is tied 0.

Test Plan:
- Two simultaneous writes: req0 A=0x0010 D=0xAA, req1 A=0x0020 D=0x55, from reset -> cycle 1 grants req0, cycle 2 grants req1 (wptr = 1 after the first grant); a readback returns 0xAA / 0x55 with RSP_VALID one cycle after each read grant.
- Concurrent read and write: req0 writes 0x7FFF = 0x3C while req1 reads 0x0010 (holding 0xAA) -> both READY in the same cycle; next cycle RSP_VALID = 2'b10, RSP_Q = 0xAA.
- Hazard: req0 writes 0x0100 = 0x12 while req1 reads 0x0100 -> the read stalls one cycle (CE1 = 0), is granted next cycle, and returns 0x12.
- Masked write: 0x0005 holds 0xFF; write D=0x00 with WEM=0x0F -> readback 0xF0.
- Fairness: both requesters continuously reading -> grants alternate 0,1,0,1 for 8 cycles and RSP_VALID alternates accordingly.
- With SRAM_B_ARB_ZERO_INIT_EN: release reset -> INIT_BUSY high for exactly 32768 cycles with no READY; then a read of 0x1234 returns 0x00. Assert RSTN low at cycle 100 of init -> init restarts at addr 0.
